// File: rtl/pm_loader_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pm_loader_pkg                                                    |
// | Shared types for the program-memory loader and its CPU side.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package pm_loader_pkg;

    localparam int c_def_add_width  = 8;
    localparam int c_def_data_width = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
    } loader_state_t;

    typedef struct packed {
        logic                        wr_en;
        logic [c_def_add_width-1:0]  addr;
        logic [c_def_data_width-1:0] data;
    } pm_wr_t;

endpackage
`default_nettype wire

// File: rtl/pm_loader_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pm_loader_if                                                     |
// | Load control, byte stream and program-memory write port.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface pm_loader_if
    import pm_loader_pkg::*;
#(
    parameter int ADD_WIDTH  = c_def_add_width,
    parameter int DATA_WIDTH = c_def_data_width
);
    logic                  load_start;
    logic [ADD_WIDTH:0]    load_len;
    logic                  load_abort;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  pmWrEn;
    logic [DATA_WIDTH-1:0] instructionIn;
    logic [ADD_WIDTH-1:0]  pm_addr;
    logic                  cpu_run;
    logic                  load_done;
    logic                  load_err;

    modport master (
        output load_start, load_len, load_abort, s_valid, s_data,
        input  s_ready, pmWrEn, instructionIn, pm_addr, cpu_run, load_done, load_err
    );

    modport slave (
        input  load_start, load_len, load_abort, s_valid, s_data,
        output s_ready, pmWrEn, instructionIn, pm_addr, cpu_run, load_done, load_err
    );

endinterface
`default_nettype wire

// File: rtl/pm_loader_wr_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pm_loader_wr_reg                                                 |
// | One-stage output register for the program-memory write bundle.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pm_loader_wr_reg #(
    parameter int ADD_WIDTH  = 8,
    parameter int DATA_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_wr_en,
    input  wire logic [ADD_WIDTH-1:0]  i_addr,
    input  wire logic [DATA_WIDTH-1:0] i_data,
    output logic                       o_wr_en,
    output logic [ADD_WIDTH-1:0]       o_addr,
    output logic [DATA_WIDTH-1:0]      o_data
);

    // Address and data hold their last written value between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_wr_en <= 1'b0;
            o_addr  <= '0;
            o_data  <= '0;
        end else begin
            o_wr_en <= i_wr_en;
            if (i_wr_en) begin
                o_addr <= i_addr;
                o_data <= i_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pm_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pm_loader                                                        |
// | Streams a program image into program memory, checks its XOR sum. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pm_loader
    import pm_loader_pkg::*;
#(
    parameter int ADD_WIDTH  = c_def_add_width,
    parameter int DATA_WIDTH = c_def_data_width
) (
    input  wire logic  clk,
    input  wire logic  rst,
    pm_loader_if.slave bus
);

    localparam logic [ADD_WIDTH:0] c_max_len = {1'b1, {ADD_WIDTH{1'b0}}};

    loader_state_t         r_state;
    logic [ADD_WIDTH:0]    r_len;
    logic [ADD_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_csum;
    logic                  r_cpu_run;
    logic                  r_load_done;
    logic                  r_load_err;

    logic w_s_ready;
    logic w_take;
    logic w_len_ok;
    logic w_wr_en;

    assign w_s_ready = (r_state == LOAD) || (r_state == CHECK);
    // Abort masks the handshake so an aborted byte is never written.
    assign w_take    = bus.s_valid && w_s_ready && !bus.load_abort;
    assign w_len_ok  = (bus.load_len != '0) && (bus.load_len <= c_max_len);
    assign w_wr_en   = w_take && (r_state == LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_csum      <= '0;
            r_cpu_run   <= 1'b0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
                IDLE, RUN, ERR: begin
                    if (bus.load_start) begin
                        r_cpu_run <= 1'b0;
                        if (w_len_ok) begin
                            r_state    <= LOAD;
                            r_len      <= bus.load_len;
                            r_cnt      <= '0;
                            r_csum     <= '0;
                            r_load_err <= 1'b0;
                        end else begin
                            r_state    <= ERR;
                            r_load_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.load_abort) begin
                        r_state <= IDLE;
                    end else if (w_take) begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_csum <= r_csum ^ bus.s_data;
                        if ({1'b0, r_cnt} == r_len - 1'b1) begin
                            r_state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (bus.load_abort) begin
                        r_state <= IDLE;
                    end else if (w_take) begin
                        if (bus.s_data == r_csum) begin
                            r_state     <= RUN;
                            r_cpu_run   <= 1'b1;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state    <= ERR;
                            r_load_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    pm_loader_wr_reg #(
        .ADD_WIDTH  (ADD_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_reg (
        .clk     (clk),
        .rst     (rst),
        .i_wr_en (w_wr_en),
        .i_addr  (r_cnt),
        .i_data  (bus.s_data),
        .o_wr_en (bus.pmWrEn),
        .o_addr  (bus.pm_addr),
        .o_data  (bus.instructionIn)
    );

    assign bus.s_ready   = w_s_ready;
    assign bus.cpu_run   = r_cpu_run;
    assign bus.load_done = r_load_done;
    assign bus.load_err  = r_load_err;

endmodule
`default_nettype wire
